obi_mem_responder: RTL
======================

# obi_mem_responder

OBI responder (slave) end of the core instruction/data memory interface: accepts `obi_req_t` transactions from an initiator (CPU core, data crossbar slave port, or accelerator master) and returns `obi_resp_t` responses from a word-organised, byte-writable local memory. Grant wait-states and read latency are programmable at elaboration so the bench and the MCU can exercise initiators against realistic slow responders. The block sits behind the bus decoder and checks its own address window; out-of-window accesses complete with a fixed pattern and are counted.

## Interface
- `NUM_WORDS`, 1024: memory depth in 32-bit words; power of two, 16..65536.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; NUM_WORDS*4-aligned.
- `GNT_WAIT`, 0: cycles `req` must be held before `gnt` is given; 0..15.
- `RVALID_LAT`, 1: cycles from grant to `rvalid`; 1..4.
- `clk_i`  in  1  clock; all state is on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_i`  in  obi_req_t  `req`, `addr[31:0]`, `we`, `be[3:0]`, `wdata[31:0]`.
- `resp_o`  out  obi_resp_t  `gnt`, `rvalid`, `rdata[31:0]`.
- `err_count_o`  out  16  saturating count of out-of-window accesses.
- `busy_o`  out  1  high while any granted transaction has not yet produced `rvalid`.

## Operation
- Window check: `off = addr - BASE_ADDR` (32-bit, wraps); in-window iff `off < NUM_WORDS*4`. Word index `off[2 +: log2(NUM_WORDS)]`; `addr[1:0]` ignored.
- Grant FSM, states IDLE / WAIT:
  - IDLE: `req`=0 stays IDLE. `req`=1 and GNT_WAIT=0: `gnt`=1 same cycle, stay IDLE. `req`=1 and GNT_WAIT>0: go WAIT, wait counter = 1.
  - WAIT: `gnt`=1 when `req`=1 and counter == GNT_WAIT, then return to IDLE (counter cleared). Else counter increments. `req` dropping in WAIT (protocol violation) returns to IDLE, counter cleared, no grant, no side effects.
  - `gnt` is combinational from `req_i.req` and FSM state; never asserted with `req`=0.
- Accept: transaction occurs in the cycle `req && gnt`.
  - Write, in-window: bytes with `be[i]`=1 updated from `wdata[8i+7:8i]` at that clock edge; others unchanged. Response `rdata` = 0.
  - Read, in-window: memory word read at accept; `rdata` = that word (pre-edge value for the same cycle; no same-cycle write is possible).
  - Out-of-window: write dropped; read returns 32'hBADC_AB1E; `err_count_o` increments (saturates at 16'hFFFF).
  - `be`=4'b0000 write: legal, memory unchanged, normal response.
- Response pipeline: shift register of RVALID_LAT stages, each {valid, data}; stage 0 loaded on accept, shifts every cycle unconditionally (no back-pressure; OBI initiator must accept `rvalid`). Every accepted transaction, read or write, produces exactly one `rvalid` pulse, in order.
- `busy_o` = OR of pipeline valid bits.
- Memory contents are not reset.

## Timing
- Reset values: `gnt`=0 (with `req`=0), `rvalid`=0, `rdata`=0, `err_count_o`=0, `busy_o`=0, FSM IDLE, counter 0, pipeline cleared.
- Reset asserted mid-operation: pipeline flushed; in-flight responses are lost (never emitted); a write accepted in the same cycle reset asserts is not guaranteed.
- Grant latency: `gnt` in cycle K+GNT_WAIT when `req` rises in cycle K and is held.
- Read latency: accept in cycle N -> `rvalid`=1 with data in cycle N+RVALID_LAT, for exactly one cycle.
- Throughput with GNT_WAIT=0: one transaction per cycle; back-to-back accepts give back-to-back `rvalid`.
- Write at cycle N, read same word accepted at N+1: read returns new data.
- With GNT_WAIT>0, after a grant FSM returns to IDLE; a held `req` restarts the wait, so peak rate is one per GNT_WAIT+1 cycles.

## Test plan
- GNT_WAIT=0, RVALID_LAT=1: write 32'hDEAD_BEEF to BASE+0x10 (be=4'hF), read it next cycle -> read `rvalid` one cycle after its accept, `rdata`=32'hDEAD_BEEF; write response `rdata`=0.
- Byte enables: word holds 32'h1122_3344, write 32'hAABB_CCDD with be=4'b0101 -> read returns 32'h11BB_33DD.
- GNT_WAIT=3, RVALID_LAT=4: `req` raised at cycle 10 and held -> `gnt` at 13 only, `rvalid` at 17; `busy_o` high cycles 14..17.
- Out-of-window: NUM_WORDS=1024, BASE=0, read at 0x1000 and write at 0xFFFF_FFFC -> read `rdata`=32'hBADC_AB1E, memory unchanged, `err_count_o`=2.
- Streaming: GNT_WAIT=0, RVALID_LAT=2, 8 back-to-back reads of preloaded words 0..7 -> 8 consecutive `rvalid` cycles, data in order.
- Reset: assert `rst_i` one cycle after a read accept with RVALID_LAT=3 -> no `rvalid` emitted, all outputs at reset values, `err_count_o`=0.

Source files
------------

// File: rtl/obi_mem_responder.sv
// OBI responder with a word-organised, byte-writable local memory.
// Programmable grant wait-states and read latency; out-of-window accesses are counted.
package obi_pkg;
   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;
endpackage

module obi_mem_responder
   import obi_pkg::*;
#(
   parameter int unsigned NUM_WORDS  = 1024,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned GNT_WAIT   = 0,
   parameter int unsigned RVALID_LAT = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  obi_req_t    req_i,
   output obi_resp_t   resp_o,
   output logic [15:0] err_count_o,
   output logic        busy_o
);

   localparam int unsigned AW = $clog2(NUM_WORDS);
   localparam logic [31:0] WIN = 32'(NUM_WORDS * 4);
   localparam logic [3:0]  GW = 4'(GNT_WAIT);
   localparam logic [31:0] OOW_DATA = 32'hBADC_AB1E;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        gnt;
   logic        accept;
   logic [31:0] off;
   logic        in_win;
   logic [AW-1:0] idx;
   logic [31:0] rd_data;

   logic [31:0]           mem [NUM_WORDS];
   logic [RVALID_LAT-1:0] vld_q;
   logic [31:0]           dat_q [RVALID_LAT];
   logic [15:0]           err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_i.req) begin
               if (GNT_WAIT == 0) begin
                  gnt = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'd1;
               end
            end
         end
         WAIT: begin
            // a dropped request abandons the wait without side effects
            if (!req_i.req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == GW) begin
               gnt     = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign accept = req_i.req && gnt;
   assign off    = req_i.addr - BASE_ADDR;
   assign in_win = off < WIN;
   assign idx    = off[2 +: AW];

   always_comb begin
      rd_data = '0;
      if (!req_i.we) begin
         rd_data = in_win ? mem[idx] : OOW_DATA;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept && in_win && req_i.we) begin
         for (int i = 0; i < 4; i++) begin
            if (req_i.be[i]) begin
               mem[idx][8*i +: 8] <= req_i.wdata[8*i +: 8];
            end
         end
      end
   end

   // response pipeline never stalls: the initiator must take every rvalid
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q <= '0;
         for (int i = 0; i < RVALID_LAT; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= accept;
         dat_q[0] <= accept ? rd_data : 32'h0;
         for (int i = 1; i < RVALID_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= '0;
      end else if (accept && !in_win && err_q != 16'hFFFF) begin
         err_q <= err_q + 16'd1;
      end
   end

   assign resp_o.gnt    = gnt;
   assign resp_o.rvalid = vld_q[RVALID_LAT-1];
   assign resp_o.rdata  = dat_q[RVALID_LAT-1];
   assign err_count_o   = err_q;
   assign busy_o        = |vld_q;

endmodule
